hack_vga_scanout: RTL and testbench



---
 rtl/hack_vga_pkg.sv | 39 +++
 rtl/vga_timing_gen.sv | 73 +++++++
 rtl/hack_vga_scanout.sv | 172 +++++++++++++++++
 tb/tb_hack_vga_scanout.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_vga_pkg.sv
// Shared constants for the Hack VGA scanout: 640x480@60 timing, the centred
// 512x256 1-bpp window, colours and a small range helper.
// Optional build macro: HACK_VGA_BORDER_EN (red 1-pixel ring around the window).
package hack_vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int X_OFFSET = 64;
  localparam int Y_OFFSET = 112;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  localparam int WIN_W         = 512;
  localparam int WIN_H         = 256;
  localparam int WORDS_PER_ROW = 32;
  localparam int WORD_W        = 16;
  localparam int CNT_W         = 10;
  localparam int ADDR_W        = 13;

  localparam logic [2:0] FG_COLOR     = 3'b000;
  localparam logic [2:0] BG_COLOR     = 3'b111;
  localparam logic [2:0] BLANK_COLOR  = 3'b000;
  localparam logic [2:0] BORDER_COLOR = 3'b100;

  // Half-open range test lo <= x < hi on raster coordinates.
  function automatic logic in_span(input logic [CNT_W-1:0] x,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus combinational decode of sync, active area and window.
// Consumers register everything they drive off-chip.
import hack_vga_pkg::*;

module vga_timing_gen #(
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int H_FP_P     = H_FP,
  parameter int H_SYNC_P   = H_SYNC,
  parameter int H_BP_P     = H_BP,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int V_FP_P     = V_FP,
  parameter int V_SYNC_P   = V_SYNC,
  parameter int V_BP_P     = V_BP,
  parameter int X_OFFSET_P = X_OFFSET,
  parameter int Y_OFFSET_P = Y_OFFSET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_locked,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             win_x,
  output logic             win_y
);

  localparam logic [CNT_W-1:0] H_LAST_L   = CNT_W'(H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
  localparam logic [CNT_W-1:0] V_LAST_L   = CNT_W'(V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P - 1);
  localparam logic [CNT_W-1:0] H_ACT_L    = CNT_W'(H_ACTIVE_P);
  localparam logic [CNT_W-1:0] V_ACT_L    = CNT_W'(V_ACTIVE_P);
  localparam logic [CNT_W-1:0] HS_BEG_L   = CNT_W'(H_ACTIVE_P + H_FP_P);
  localparam logic [CNT_W-1:0] HS_END_L   = CNT_W'(H_ACTIVE_P + H_FP_P + H_SYNC_P);
  localparam logic [CNT_W-1:0] VS_BEG_L   = CNT_W'(V_ACTIVE_P + V_FP_P);
  localparam logic [CNT_W-1:0] VS_END_L   = CNT_W'(V_ACTIVE_P + V_FP_P + V_SYNC_P);
  localparam logic [CNT_W-1:0] X_BEG_L    = CNT_W'(X_OFFSET_P);
  localparam logic [CNT_W-1:0] X_END_L    = CNT_W'(X_OFFSET_P + WIN_W);
  localparam logic [CNT_W-1:0] Y_BEG_L    = CNT_W'(Y_OFFSET_P);
  localparam logic [CNT_W-1:0] Y_END_L    = CNT_W'(Y_OFFSET_P + WIN_H);

  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;

  // Advance the raster; a lost pixel clock parks both counters at the origin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_r <= {CNT_W{1'b0}};
      v_cnt_r <= {CNT_W{1'b0}};
    end else if (!clk_locked) begin
      h_cnt_r <= {CNT_W{1'b0}};
      v_cnt_r <= {CNT_W{1'b0}};
    end else if (h_cnt_r == H_LAST_L) begin
      h_cnt_r <= {CNT_W{1'b0}};
      if (v_cnt_r == V_LAST_L) begin
        v_cnt_r <= {CNT_W{1'b0}};
      end else begin
        v_cnt_r <= v_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      h_cnt_r <= h_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign h_cnt   = h_cnt_r;
  assign v_cnt   = v_cnt_r;
  assign active  = (h_cnt_r < H_ACT_L) && (v_cnt_r < V_ACT_L);
  assign hsync_n = !in_span(h_cnt_r, HS_BEG_L, HS_END_L);
  assign vsync_n = !in_span(v_cnt_r, VS_BEG_L, VS_END_L);
  assign win_x   = in_span(h_cnt_r, X_BEG_L, X_END_L);
  assign win_y   = in_span(v_cnt_r, Y_BEG_L, Y_END_L);

endmodule

// File: rtl/hack_vga_scanout.sv
// Hack screen scanout: fetches 16-bit screen words one window-word ahead,
// serialises them LSB-first and drives registered VGA pins.
// Optional build macro: HACK_VGA_BORDER_EN (red ring just outside the window).
import hack_vga_pkg::*;

module hack_vga_scanout #(
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int H_FP_P     = H_FP,
  parameter int H_SYNC_P   = H_SYNC,
  parameter int H_BP_P     = H_BP,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int V_FP_P     = V_FP,
  parameter int V_SYNC_P   = V_SYNC,
  parameter int V_BP_P     = V_BP,
  parameter int X_OFFSET_P = X_OFFSET,
  parameter int Y_OFFSET_P = Y_OFFSET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_locked,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_data,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [2:0]        vga_rgb,
  output logic              frame_start
);

  // The read strobe must be high at X_OFFSET-2+16k, so it is set one edge earlier.
  localparam logic [CNT_W-1:0] FETCH_BEG_L = CNT_W'(X_OFFSET_P - 3);
  localparam logic [CNT_W-1:0] FETCH_SPAN_L = CNT_W'(WIN_W);
  localparam logic [CNT_W-1:0] Y_BEG_L = CNT_W'(Y_OFFSET_P);

  logic [CNT_W-1:0]  h_cnt_s;
  logic [CNT_W-1:0]  v_cnt_s;
  logic              active_s;
  logic              hsync_n_s;
  logic              vsync_n_s;
  logic              win_x_s;
  logic              win_y_s;
  logic              win_s;
  logic              border_s;
  logic [CNT_W-1:0]  fetch_off_s;
  logic              fetch_hit_s;
  logic [7:0]        row_s;
  logic [4:0]        word_s;
  logic [2:0]        rgb_s;

  logic              mem_rd_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              rd_d_r;
  logic [WORD_W-1:0] shift_r;
  logic              hsync_r;
  logic              vsync_r;
  logic [2:0]        rgb_r;
  logic              frame_start_r;

  vga_timing_gen #(
    .H_ACTIVE_P (H_ACTIVE_P), .H_FP_P (H_FP_P), .H_SYNC_P (H_SYNC_P), .H_BP_P (H_BP_P),
    .V_ACTIVE_P (V_ACTIVE_P), .V_FP_P (V_FP_P), .V_SYNC_P (V_SYNC_P), .V_BP_P (V_BP_P),
    .X_OFFSET_P (X_OFFSET_P), .Y_OFFSET_P (Y_OFFSET_P)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .clk_locked (clk_locked),
    .h_cnt      (h_cnt_s),
    .v_cnt      (v_cnt_s),
    .active     (active_s),
    .hsync_n    (hsync_n_s),
    .vsync_n    (vsync_n_s),
    .win_x      (win_x_s),
    .win_y      (win_y_s)
  );

  assign win_s       = win_x_s && win_y_s;
  assign fetch_off_s = h_cnt_s - FETCH_BEG_L;
  assign fetch_hit_s = win_y_s && (h_cnt_s >= FETCH_BEG_L) &&
                       (fetch_off_s < FETCH_SPAN_L) && (fetch_off_s[3:0] == 4'd0);
  assign row_s       = 8'(v_cnt_s - Y_BEG_L);
  assign word_s      = 5'(fetch_off_s >> 4);

`ifdef HACK_VGA_BORDER_EN
  localparam logic [CNT_W-1:0] BX_LO_L = CNT_W'(X_OFFSET_P - 1);
  localparam logic [CNT_W-1:0] BX_HI_L = CNT_W'(X_OFFSET_P + WIN_W);
  localparam logic [CNT_W-1:0] BY_LO_L = CNT_W'(Y_OFFSET_P - 1);
  localparam logic [CNT_W-1:0] BY_HI_L = CNT_W'(Y_OFFSET_P + WIN_H);
  assign border_s =
    (((h_cnt_s == BX_LO_L) || (h_cnt_s == BX_HI_L)) && (v_cnt_s >= BY_LO_L) && (v_cnt_s <= BY_HI_L)) ||
    (((v_cnt_s == BY_LO_L) || (v_cnt_s == BY_HI_L)) && (h_cnt_s >= BX_LO_L) && (h_cnt_s <= BX_HI_L));
`else
  assign border_s = 1'b0;
`endif

  // Issue one screen-word read per 16 window pixels, only on window lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rd_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      rd_d_r     <= 1'b0;
    end else if (!clk_locked) begin
      mem_rd_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      rd_d_r     <= 1'b0;
    end else begin
      mem_rd_r <= fetch_hit_s;
      rd_d_r   <= mem_rd_r;
      if (fetch_hit_s) begin
        mem_addr_r <= {row_s, word_s};
      end else begin
        mem_addr_r <= mem_addr_r;
      end
    end
  end

  // Load returned data only in the cycle after a read; otherwise shift LSB-first in the window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r <= {WORD_W{1'b0}};
    end else if (!clk_locked) begin
      shift_r <= {WORD_W{1'b0}};
    end else if (rd_d_r) begin
      shift_r <= mem_data;
    end else if (win_s) begin
      shift_r <= {1'b0, shift_r[WORD_W-1:1]};
    end else begin
      shift_r <= shift_r;
    end
  end

  // Pixel colour for the current raster position.
  always_comb begin
    rgb_s = BLANK_COLOR;
    if (!active_s) begin
      rgb_s = BLANK_COLOR;
    end else if (win_s) begin
      rgb_s = shift_r[0] ? FG_COLOR : BG_COLOR;
    end else if (border_s) begin
      rgb_s = BORDER_COLOR;
    end else begin
      rgb_s = BG_COLOR;
    end
  end

  // Register all VGA outputs together so sync and colour stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      rgb_r         <= 3'b000;
      frame_start_r <= 1'b0;
    end else if (!clk_locked) begin
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      rgb_r         <= 3'b000;
      frame_start_r <= 1'b0;
    end else begin
      hsync_r       <= hsync_n_s;
      vsync_r       <= vsync_n_s;
      rgb_r         <= rgb_s;
      frame_start_r <= (h_cnt_s == {CNT_W{1'b0}}) && (v_cnt_s == {CNT_W{1'b0}});
    end
  end

  assign mem_rd      = mem_rd_r;
  assign mem_addr    = mem_addr_r;
  assign vga_hsync   = hsync_r;
  assign vga_vsync   = vsync_r;
  assign vga_rgb     = rgb_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_hack_vga_scanout.sv
// Bench for hack_vga_scanout with a shortened vertical raster (14 lines,
// window starting on line 2) so several frames fit in a short run.
module tb_hack_vga_scanout;

  localparam int XO = 64;
  localparam int YO = 2;
  localparam int VA = 8;
  localparam int VFP = 2;
  localparam int VS = 2;
  localparam int VBP = 2;
  localparam int HT = 800;
  localparam int VT = VA + VFP + VS + VBP;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_locked;
  logic [12:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [2:0]  vga_rgb;
  logic        frame_start;

  logic [15:0] mem [0:8191];
  int vectors = 0;
  int miscompares = 0;
  int mh = 0, mv = 0, ph = 0, pv = 0;
  bit pvalid = 1'b0;
  int cyc = 0;
  int fs_cnt = 0;
  int hfall = -1, vfall = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  logic rd_s = 1'b0;
  logic [12:0] addr_s = 13'd0;

  always #20 clk = ~clk;

  hack_vga_scanout #(
    .V_ACTIVE_P (VA), .V_FP_P (VFP), .V_SYNC_P (VS), .V_BP_P (VBP), .Y_OFFSET_P (YO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .clk_locked  (clk_locked),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_rgb     (vga_rgb),
    .frame_start (frame_start)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL %s: got %0d, expected %0d (counter h=%0d v=%0d, cycle %0d)",
                 name, act, exp, mh, mv, cyc);
    end
  endtask

  function automatic int exp_rgb(input int h, input int v);
    logic [15:0] w;
    if (!(h < 640 && v < VA)) return 0;
    if (h >= XO && h < XO + 512 && v >= YO && v < YO + 256) begin
      w = mem[(v - YO) * 32 + (h - XO) / 16];
      return w[(h - XO) % 16] ? 0 : 7;
    end
`ifdef HACK_VGA_BORDER_EN
    if (((h == XO - 1 || h == XO + 512) && v >= YO - 1 && v <= YO + 256) ||
        ((v == YO - 1 || v == YO + 256) && h >= XO - 1 && h <= XO + 512)) return 4;
`endif
    return 7;
  endfunction

  function automatic int exp_rd(input int h, input int v);
    return (v >= YO && v < YO + 256 && h >= XO - 2 && h < XO - 2 + 512 &&
            ((h - (XO - 2)) % 16) == 0) ? 1 : 0;
  endfunction

  // Raster model: (mh,mv) is the counter during the coming cycle, (ph,pv) the previous one.
  always @(posedge clk) begin
    if (!rst_n || !clk_locked) begin
      pvalid = 1'b0;
      mh = 0;
      mv = 0;
    end else begin
      pvalid = 1'b1;
      ph = mh;
      pv = mv;
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
    end
  end

  // Memory: return the addressed word the cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    #1;
    mem_data = rd_s ? mem[addr_s] : 16'($urandom);
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (frame_start) fs_cnt++;
    if (pvalid) begin
      check("hsync", vga_hsync, (ph >= 656 && ph < 752) ? 0 : 1);
      check("vsync", vga_vsync, (pv >= VA + VFP && pv < VA + VFP + VS) ? 0 : 1);
      check("rgb", vga_rgb, exp_rgb(ph, pv));
      check("frame_start", frame_start, (ph == 0 && pv == 0) ? 1 : 0);
      if (pv == YO && ph == XO) check("pix_first_black", vga_rgb, 0);
      if (pv == YO && ph > XO && ph < XO + 512) check("pix_row0_white", vga_rgb, 7);
`ifdef HACK_VGA_BORDER_EN
      if (pv == YO + 3 && ph == XO - 1) check("pix_left_ring", vga_rgb, 4);
`else
      if (pv == YO + 3 && ph == XO - 1) check("pix_left_ring", vga_rgb, 7);
`endif
      if (ph == 700) check("blank_rgb", vga_rgb, 0);
      if (prev_hs && !vga_hsync) begin
        if (hfall >= 0) check("h_period", cyc - hfall, 800);
        hfall = cyc;
      end
      if (!prev_hs && vga_hsync && hfall >= 0) check("h_low", cyc - hfall, 96);
      if (prev_vs && !vga_vsync) begin
        if (vfall >= 0) check("v_period", cyc - vfall, VT * HT);
        vfall = cyc;
      end
      if (!prev_vs && vga_vsync && vfall >= 0) check("v_low", cyc - vfall, VS * HT);
      prev_hs = vga_hsync;
      prev_vs = vga_vsync;
    end else begin
      check("rst_hsync", vga_hsync, 1);
      check("rst_vsync", vga_vsync, 1);
      check("rst_rgb", vga_rgb, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_mem_addr", mem_addr, 0);
      hfall = -1;
      vfall = -1;
      prev_hs = 1'b1;
      prev_vs = 1'b1;
    end
    check("mem_rd", mem_rd, exp_rd(mh, mv));
    if (exp_rd(mh, mv) == 1)
      check("mem_addr", mem_addr, (mv - YO) * 32 + (mh - (XO - 2)) / 16);
    rd_s = mem_rd;
    addr_s = mem_addr;
  end

  task automatic wait_pos(input int h, input int v, input int budget);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_pos_reached", (mh == h && mv == v) ? 1 : 0, 1);
  endtask

  initial begin
    int fs0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0001;
    for (int i = 1; i < 32; i++) mem[i] = 16'h0000;
    rst_n = 1'b0;
    clk_locked = 1'b0;
    mem_data = 16'h0000;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clk_locked = 1'b1;

    // Lose the pixel clock mid-frame, then confirm a single restart pulse.
    wait_pos(300, 5, 20000);
    @(posedge clk);
    #1 clk_locked = 1'b0;
    repeat (10) @(posedge clk);
    #1 clk_locked = 1'b1;
    fs0 = fs_cnt;
    repeat (20) @(posedge clk);
    check("restart_frame_pulses", fs_cnt - fs0, 1);

    // Steady scanning across several frames.
    fs0 = fs_cnt;
    repeat (3 * VT * HT) @(posedge clk);
    check("frames_in_3_periods", fs_cnt - fs0, 3);

    // Random short clock-loss events.
    repeat (4) begin
      repeat ($urandom_range(50, 3000)) @(posedge clk);
      #1 clk_locked = 1'b0;
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1 clk_locked = 1'b1;
    end
    repeat (2000) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
